venom_anim_ctrl: RTL
====================

# venom_anim_ctrl

Animation sequencer and address generator for the venom projectile sprite sheet. It is launched by gameplay logic at a screen position and steps through the sheet's frames, one frame per programmable number of video frames. Each pixel clock it outputs the sprite ROM address and a `sprite_on` qualifier for the current `DrawX`/`DrawY`. It sits between game logic and the venom sprite ROM and palette, replacing a full-screen stretch with a positioned, frame-selected 30x30 window.

## Interface
- `FRAME_W`, 30, frame width in pixels (sheet width)
- `FRAME_H`, 30, frame height in pixels
- `NUM_FRAMES`, 7, frames stacked vertically in the sheet (sheet 30x210)
- `TICKS_PER_FRAME`, 4, video frames each animation frame is shown
- `vga_clk`  in  1  pixel clock; all logic on posedge
- `reset_n`  in  1  synchronous, active-low reset
- `frame_tick`  in  1  one-cycle pulse at start of vertical blank
- `fire`  in  1  launch request pulse
- `fire_x`, `fire_y`  in  10  top-left launch position, sampled with `fire`
- `stop`  in  1  end request (used only with `VENOM_ANIM_LOOP_EN`)
- `DrawX`, `DrawY`  in  10  current pixel coordinates
- `busy`  out  1  animation active
- `done`  out  1  one-cycle pulse when the animation completes
- `frame_idx`  out  3  current frame number
- `sprite_on`  out  1  registered: current pixel lies inside the active sprite box
- `rom_address`  out  13  registered sprite ROM address

## Operation
- States: IDLE, PLAY, DONE.
- IDLE: `fire`=1 latches `fire_x`/`fire_y` into `pos_x`/`pos_y`, clears `frame_idx` and `tick_cnt`, and moves to PLAY. `stop` is ignored.
- PLAY: each `frame_tick` increments `tick_cnt`. When `frame_tick` arrives with `tick_cnt`==`TICKS_PER_FRAME`-1, `tick_cnt` returns to 0 and the frame advances:
  - if `frame_idx`<`NUM_FRAMES`-1, `frame_idx`+1;
  - otherwise the last frame has finished: go to DONE, with `frame_idx` held.
- `fire` in PLAY or DONE is ignored; position is not re-latched.
- DONE: lasts one cycle with `done`=1, then IDLE. `frame_idx` clears on entering IDLE.
- `busy`=1 in PLAY only.
- Pixel box: `sprite_on_next` = PLAY, `DrawX`>=`pos_x`, `DrawX`<`pos_x`+`FRAME_W`, `DrawY`>=`pos_y`, `DrawY`<`pos_y`+`FRAME_H`.
  - Comparisons use 11-bit arithmetic, so a box that extends past x=639 or y=479 does not wrap.
- Address: `rom_address_next` = (`DrawY`-`pos_y`)*`FRAME_W` + (`DrawX`-`pos_x`) + `frame_idx`*`FRAME_W`*`FRAME_H`, truncated to 13 bits.
  - The maximum is 6299, so no overflow at default parameters.
  - `rom_address_next` is 0 when `sprite_on_next`=0.

## Timing
- All outputs reset to 0 and the state resets to IDLE. Reset during PLAY aborts with no `done` pulse.
- `sprite_on` and `rom_address` are registered, 1 cycle after `DrawX`/`DrawY`. The ROM samples on the negedge and the palette output is registered on the next posedge, so the pipeline aligns with the downstream blank/colour register.
- `busy` rises the cycle after an accepted `fire`. The first `sprite_on` is possible 1 cycle after that.
- `frame_idx` changes only on `frame_tick` cycles, i.e. in vblank, so frames never tear.
- One-shot length: `NUM_FRAMES`*`TICKS_PER_FRAME` `frame_tick` pulses from launch to `done`.
- `frame_tick` coincident with `fire` in IDLE is not counted.

## Configuration
- `VENOM_ANIM_LOOP_EN` defined: in PLAY, the advance from frame `NUM_FRAMES`-1 wraps `frame_idx` to 0 and stays in PLAY, so the animation loops.
  - `stop`=1 in PLAY forces DONE on the next cycle, which pulses `done`.
  - `stop` coincident with a frame advance: `stop` wins.
- Not defined: one-shot behaviour as above. `stop` is ignored everywhere.

## Test plan
- Reset:
  - Hold `reset_n`=0 for 3 cycles: `busy`, `done`, `frame_idx`, `sprite_on`, `rom_address` all 0.
  - `fire` while `reset_n`=0: still IDLE after release.
- One-shot:
  - `fire` at (100,50), then 28 `frame_tick` pulses: `frame_idx` steps 0..6 every 4 ticks.
  - `done` pulses exactly once, 1 cycle after the 28th tick, and `busy` falls with it.
- Addressing:
  - In frame 2, `DrawX`=105, `DrawY`=53: `rom_address`=1895 and `sprite_on`=1 one cycle later.
  - `DrawX`=130 gives `sprite_on`=0 and `rom_address`=0.
  - `DrawX`=99 gives `sprite_on`=0.
- Edge clipping:
  - `fire` at (625,470), `DrawX`=5: `sprite_on`=0, with no wrap to the left side.
  - `DrawX`=639, `DrawY`=479: `sprite_on`=1 and `rom_address`=9*30+14=284 in frame 0.
- Ignored fire / abort:
  - Second `fire` at (0,0) mid-animation leaves `pos` at (100,50).
  - `reset_n`=0 at frame 3: no `done`, all outputs 0.
- Loop (macro on):
  - After the 28th tick, `frame_idx`=0 and `busy`=1.
  - `stop` pulse: `done` pulses the next cycle, then IDLE.

Source files
------------

// File: rtl/venom_anim_ctrl_if.sv
// Game-logic and pixel-pipeline signal bundle for venom_anim_ctrl.
// master: gameplay/video side driving launch and scan position.
// slave : the animation controller.
interface venom_anim_ctrl_if;
    logic        fire;
    logic [9:0]  fire_x;
    logic [9:0]  fire_y;
    logic        stop;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        busy;
    logic        done;
    logic [2:0]  frame_idx;
    logic        sprite_on;
    logic [12:0] rom_address;

    modport master (
        output fire, fire_x, fire_y, stop, DrawX, DrawY,
        input  busy, done, frame_idx, sprite_on, rom_address
    );

    modport slave (
        input  fire, fire_x, fire_y, stop, DrawX, DrawY,
        output busy, done, frame_idx, sprite_on, rom_address
    );
endinterface

// File: rtl/venom_anim_ctrl.sv
// Venom projectile animation sequencer and sprite ROM address generator.
// Launches at a screen position, steps through NUM_FRAMES frames stacked
// vertically in the sheet (one per TICKS_PER_FRAME video frames), and
// produces a registered sprite_on / rom_address for the current pixel.
// Optional: define VENOM_ANIM_LOOP_EN to loop the animation until stop.
module venom_anim_ctrl #(
    parameter int unsigned FRAME_W         = 30,
    parameter int unsigned FRAME_H         = 30,
    parameter int unsigned NUM_FRAMES      = 7,
    parameter int unsigned TICKS_PER_FRAME = 4
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    venom_anim_ctrl_if.slave  bus
);

    localparam int unsigned TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_frame_idx;
    logic [2:0]          w_frame_next;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [TICK_W-1:0]   w_tick_next;
    logic                w_latch_pos;
    logic                w_stop;
    logic [9:0]          r_pos_x;
    logic [9:0]          r_pos_y;
    logic                r_busy;
    logic                r_done;
    logic                r_sprite_on;
    logic [12:0]         r_rom_address;

    logic [10:0]         w_x11;
    logic [10:0]         w_y11;
    logic [10:0]         w_px11;
    logic [10:0]         w_py11;
    logic [10:0]         w_dx;
    logic [10:0]         w_dy;
    logic                w_on;
    logic [12:0]         w_addr;

`ifdef VENOM_ANIM_LOOP_EN
    assign w_stop = bus.stop;
`else
    assign w_stop = 1'b0;
`endif

    // State register
    always_ff @(posedge vga_clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state, frame/tick sequencing and position latch enable
    always_comb begin
        w_state_next = r_state;
        w_frame_next = r_frame_idx;
        w_tick_next  = r_tick_cnt;
        w_latch_pos  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_frame_next = '0;
                w_tick_next  = '0;
                if (bus.fire) begin
                    w_latch_pos  = 1'b1;
                    w_state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_stop) begin
                    w_state_next = ST_DONE;
                end else if (frame_tick) begin
                    if (r_tick_cnt == TICK_W'(TICKS_PER_FRAME - 1)) begin
                        w_tick_next = '0;
                        if (r_frame_idx < 3'(NUM_FRAMES - 1)) begin
                            w_frame_next = r_frame_idx + 3'd1;
                        end else begin
`ifdef VENOM_ANIM_LOOP_EN
                            w_frame_next = '0;
`else
                            w_state_next = ST_DONE;
`endif
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + TICK_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_frame_next = '0;
                w_tick_next  = '0;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Sprite box test and address, 11-bit so boxes past the screen edge do not wrap
    assign w_x11  = {1'b0, bus.DrawX};
    assign w_y11  = {1'b0, bus.DrawY};
    assign w_px11 = {1'b0, r_pos_x};
    assign w_py11 = {1'b0, r_pos_y};
    assign w_dx   = w_x11 - w_px11;
    assign w_dy   = w_y11 - w_py11;
    assign w_on   = (r_state == ST_PLAY)
                 && (w_x11 >= w_px11) && (w_x11 < w_px11 + 11'(FRAME_W))
                 && (w_y11 >= w_py11) && (w_y11 < w_py11 + 11'(FRAME_H));
    assign w_addr = 13'(w_dy) * 13'(FRAME_W) + 13'(w_dx)
                  + 13'(r_frame_idx) * 13'(FRAME_W * FRAME_H);

    // Datapath and registered outputs
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_frame_idx   <= '0;
            r_tick_cnt    <= '0;
            r_pos_x       <= '0;
            r_pos_y       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_sprite_on   <= 1'b0;
            r_rom_address <= '0;
        end else begin
            r_frame_idx   <= w_frame_next;
            r_tick_cnt    <= w_tick_next;
            if (w_latch_pos) begin
                r_pos_x <= bus.fire_x;
                r_pos_y <= bus.fire_y;
            end
            r_busy        <= (w_state_next == ST_PLAY);
            r_done        <= (w_state_next == ST_DONE);
            r_sprite_on   <= w_on;
            r_rom_address <= w_on ? w_addr : 13'd0;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.frame_idx   = r_frame_idx;
    assign bus.sprite_on   = r_sprite_on;
    assign bus.rom_address = r_rom_address;

endmodule
